// File: rtl/reaction_timer.sv
// reaction_timer
//   Watches the start-light bar and the lights-out pulse, then measures the
//   driver's reaction time in milliseconds. Flags false starts (press before
//   lights out) and no-response timeouts at MAX_MS.
//   Optional feature macro: REACTION_BEST_EN (adds best_ms, the fastest
//   non-timeout reaction since reset).
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   lights       in   [7:0] light bar; non-zero arms a new run
//   lights_out   in   1-cycle pulse, lights extinguished
//   button       in   raw driver button, asynchronous to clk
//   reaction_ms  out  [MS_WIDTH-1:0] last measured reaction, held
//   valid        out  1-cycle pulse when reaction_ms updates
//   false_start  out  level, press seen while armed
//   timeout      out  level, no press within MAX_MS
//   busy         out  high while armed or timing
//   best_ms      out  [MS_WIDTH-1:0] best reaction (REACTION_BEST_EN only)
module reaction_timer #(
    parameter int CLK_PER_MS = 1000,
    parameter int MS_WIDTH   = 16,
    parameter int MAX_MS     = 9999
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          lights,
    input  logic                lights_out,
    input  logic                button,
    output logic [MS_WIDTH-1:0] reaction_ms,
    output logic                valid,
    output logic                false_start,
    output logic                timeout,
`ifdef REACTION_BEST_EN
    output logic                busy,
    output logic [MS_WIDTH-1:0] best_ms
`else
    output logic                busy
`endif
);

    localparam int PW = $clog2(CLK_PER_MS);
    localparam logic [PW-1:0]       PRESC_LAST = PW'(CLK_PER_MS - 1);
    localparam logic [MS_WIDTH-1:0] MS_LIMIT   = MS_WIDTH'(MAX_MS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_TIMING,
        S_DONE,
        S_FAULT
    } state_t;

    state_t              state_q;
    logic                sync1_q, sync2_q, sync3_q;
    logic [PW-1:0]       presc_q;
    logic [MS_WIDTH-1:0] count_q;
    logic [MS_WIDTH-1:0] reaction_q;
    logic                valid_q, false_start_q, timeout_q, busy_q;
`ifdef REACTION_BEST_EN
    logic [MS_WIDTH-1:0] best_q;
`endif

    logic                press;
    logic                ms_tick;
    logic [MS_WIDTH-1:0] count_d;

    always_comb begin
        // sync3_q holds the previous synchronised level for edge detection
        press   = sync2_q & ~sync3_q;
        ms_tick = (state_q == S_TIMING) && (presc_q == PRESC_LAST);
        count_d = count_q + MS_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            presc_q       <= '0;
            count_q       <= '0;
            reaction_q    <= '0;
            valid_q       <= 1'b0;
            false_start_q <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
`ifdef REACTION_BEST_EN
            best_q        <= '1;
`endif
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            valid_q <= 1'b0;

            if (state_q == S_TIMING) begin
                presc_q <= ms_tick ? '0 : presc_q + PW'(1);
            end

            unique case (state_q)
                S_IDLE, S_DONE, S_FAULT: begin
                    if (lights != '0) begin
                        state_q       <= S_ARMED;
                        busy_q        <= 1'b1;
                        false_start_q <= 1'b0;
                        timeout_q     <= 1'b0;
                    end
                end
                S_ARMED: begin
                    // a press wins over a same-cycle lights_out
                    if (press) begin
                        state_q       <= S_FAULT;
                        false_start_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end else if (lights_out) begin
                        state_q <= S_TIMING;
                        count_q <= '0;
                        presc_q <= '0;
                    end
                end
                S_TIMING: begin
                    // a press wins over a same-cycle tick or limit hit
                    if (press) begin
                        state_q    <= S_DONE;
                        reaction_q <= count_q;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b0;
`ifdef REACTION_BEST_EN
                        if (count_q < best_q) begin
                            best_q <= count_q;
                        end
`endif
                    end else if (ms_tick) begin
                        count_q <= count_d;
                        if (count_d == MS_LIMIT) begin
                            state_q    <= S_DONE;
                            reaction_q <= MS_LIMIT;
                            timeout_q  <= 1'b1;
                            valid_q    <= 1'b1;
                            busy_q     <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign reaction_ms = reaction_q;
    assign valid       = valid_q;
    assign false_start = false_start_q;
    assign timeout     = timeout_q;
    assign busy        = busy_q;
`ifdef REACTION_BEST_EN
    assign best_ms     = best_q;
`endif

endmodule
